// File: rtl/sata_pkg.sv
// Shared encodings for the SATA link alignment controller: FSM states, generation codes
// and the generation fallback helpers.
package sata_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RECONFIG = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_HUNT     = 3'd3,
    ST_LOCKED   = 3'd4,
    ST_FAIL     = 3'd5
  } state_t;

  localparam logic [1:0] GEN1 = 2'b00;
  localparam logic [1:0] GEN2 = 2'b01;
  localparam logic [1:0] GEN3 = 2'b10;

  function automatic logic [1:0] gen_lower(input logic [1:0] g);
    case (g)
      GEN3:    return GEN2;
      default: return GEN1;
    endcase
  endfunction

  // 2'b11 on max_gen means "gen3 or better", which this PHY caps at gen3.
  function automatic logic [1:0] gen_cap(input logic [1:0] g);
    return g[1] ? GEN3 : g;
  endfunction

endpackage

// File: rtl/sata_timeout_cnt.sv
// Loadable down-counter; o_zero flags expiry. Load wins over decrement, and the count
// holds at zero instead of wrapping.
module sata_timeout_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sata_link_align_ctrl.sv
// Speed negotiation and lock sequencer for the SATA receive alignment datapath:
// walks gen3->gen2->gen1 through a PHY reconfig handshake and locks after an ALIGN run.
module sata_link_align_ctrl
  import sata_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024,
  parameter int HUNT_TIMEOUT  = 65536,
  parameter int ALIGN_COUNT   = 8,
  parameter int ERR_WINDOW    = 256,
  parameter int ERR_LIMIT     = 4,
  parameter int RETRIES       = 2
) (
  input  logic       rx_clkin,
  input  logic       rx_rstn,
  input  logic       start,
  input  logic [1:0] max_gen,
  input  logic       rx_alignin,
  input  logic       rx_syncin,
  input  logic       rx_outenin,
  input  logic       rx_errin,
  output logic       reconfig_req,
  input  logic       reconfig_ack,
  output logic [1:0] sata_gen,
  output logic       link_up,
  output logic       link_fail,
  output logic [2:0] state_out
);

  localparam int TMR_MAX = (SETTLE_CYCLES > HUNT_TIMEOUT) ? SETTLE_CYCLES : HUNT_TIMEOUT;
  localparam int TW = $clog2(TMR_MAX) + 1;
  localparam int WW = $clog2(ERR_WINDOW) + 1;
  localparam int AW = $clog2(ALIGN_COUNT) + 1;
  localparam int EW = $clog2(ERR_LIMIT) + 1;
  localparam int RW = $clog2(RETRIES) + 1;
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] HUNT_LD   = TW'(HUNT_TIMEOUT - 1);
  localparam logic [WW-1:0] WIN_LD    = WW'(ERR_WINDOW - 1);

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_gen, w_gen_nxt, r_maxg, w_maxg_nxt;
  logic          r_req, w_req_nxt, r_up, w_up_nxt, r_fail, w_fail_nxt, r_pend, w_pend_nxt;
  logic [AW-1:0] r_run, w_run_nxt;
  logic [EW-1:0] r_err, w_err_nxt, w_err_sum;
  logic [RW-1:0] r_retry, w_retry_nxt;
  logic          w_qalign;
  logic          w_tmr_load, w_tmr_dec, w_tmr_zero;
  logic [TW-1:0] w_tmr_val;
  logic          w_win_load, w_win_dec, w_win_zero;

  assign w_qalign = rx_alignin & rx_outenin & rx_syncin;

  // One timer serves SETTLE and HUNT; they are never active together.
  sata_timeout_cnt #(.W(TW)) u_tmr (
    .i_clk(rx_clkin), .i_rst_n(rx_rstn), .i_load(w_tmr_load),
    .i_load_val(w_tmr_val), .i_dec(w_tmr_dec), .o_zero(w_tmr_zero)
  );

  sata_timeout_cnt #(.W(WW)) u_win (
    .i_clk(rx_clkin), .i_rst_n(rx_rstn), .i_load(w_win_load),
    .i_load_val(WIN_LD), .i_dec(w_win_dec), .o_zero(w_win_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gen_nxt   = r_gen;
    w_maxg_nxt  = r_maxg;
    w_req_nxt   = r_req;
    w_up_nxt    = r_up;
    w_fail_nxt  = r_fail;
    w_pend_nxt  = r_pend;
    w_run_nxt   = r_run;
    w_err_nxt   = r_err;
    w_retry_nxt = r_retry;
    w_tmr_load  = 1'b0;
    w_tmr_val   = HUNT_LD;
    w_tmr_dec   = 1'b0;
    w_win_load  = 1'b0;
    w_win_dec   = 1'b0;
    w_err_sum   = w_win_zero ? EW'(rx_errin) : r_err + EW'(rx_errin);

    if (start) begin
      w_state_nxt = ST_RECONFIG;
      w_maxg_nxt  = gen_cap(max_gen);
      w_up_nxt    = 1'b0;
      w_fail_nxt  = 1'b0;
      w_run_nxt   = '0;
      w_err_nxt   = '0;
      w_retry_nxt = '0;
      // An open handshake keeps its gen and req until the PHY has released ack.
      if (r_req) begin
        w_pend_nxt = 1'b1;
      end else begin
        w_gen_nxt = gen_cap(max_gen);
      end
    end else begin
      case (r_state)
        ST_RECONFIG: begin
          if (r_pend) begin
            if (!reconfig_ack) begin
              w_pend_nxt = 1'b0;
              w_gen_nxt  = r_maxg;
            end
          end else if (!r_req) begin
            w_req_nxt = !reconfig_ack;
          end else if (reconfig_ack) begin
            w_req_nxt   = 1'b0;
            w_state_nxt = ST_SETTLE;
            w_tmr_load  = 1'b1;
            w_tmr_val   = SETTLE_LD;
          end
        end
        ST_SETTLE: begin
          if (w_tmr_zero) begin
            w_state_nxt = ST_HUNT;
            w_tmr_load  = 1'b1;
            w_run_nxt   = '0;
          end else begin
            w_tmr_dec = 1'b1;
          end
        end
        ST_HUNT: begin
          if (!rx_errin && w_qalign && (int'(r_run) == ALIGN_COUNT - 1)) begin
            w_state_nxt = ST_LOCKED;
            w_up_nxt    = 1'b1;
            w_run_nxt   = '0;
            w_err_nxt   = '0;
            w_win_load  = 1'b1;
          end else begin
            if (rx_errin) w_run_nxt = '0;
            else if (w_qalign) w_run_nxt = r_run + 1'b1;
            if (!w_tmr_zero) begin
              w_tmr_dec = 1'b1;
            end else if (r_gen != GEN1) begin
              w_gen_nxt   = gen_lower(r_gen);
              w_state_nxt = ST_RECONFIG;
            end else begin
              w_retry_nxt = r_retry + 1'b1;
              if (int'(r_retry) + 1 < RETRIES) begin
                w_gen_nxt   = r_maxg;
                w_state_nxt = ST_RECONFIG;
              end else begin
                w_state_nxt = ST_FAIL;
                w_fail_nxt  = 1'b1;
              end
            end
          end
        end
        ST_LOCKED: begin
          if (!rx_syncin || (int'(w_err_sum) >= ERR_LIMIT)) begin
            w_state_nxt = ST_HUNT;
            w_up_nxt    = 1'b0;
            w_run_nxt   = '0;
            w_err_nxt   = '0;
            w_tmr_load  = 1'b1;
          end else begin
            w_err_nxt  = w_err_sum;
            w_win_load = w_win_zero;
            w_win_dec  = !w_win_zero;
          end
        end
        ST_IDLE, ST_FAIL: ;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge rx_clkin or negedge rx_rstn) begin
    if (!rx_rstn) begin
      r_state <= ST_IDLE;
      r_gen   <= GEN3;
      r_maxg  <= GEN3;
      r_req   <= 1'b0;
      r_up    <= 1'b0;
      r_fail  <= 1'b0;
      r_pend  <= 1'b0;
      r_run   <= '0;
      r_err   <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gen   <= w_gen_nxt;
      r_maxg  <= w_maxg_nxt;
      r_req   <= w_req_nxt;
      r_up    <= w_up_nxt;
      r_fail  <= w_fail_nxt;
      r_pend  <= w_pend_nxt;
      r_run   <= w_run_nxt;
      r_err   <= w_err_nxt;
      r_retry <= w_retry_nxt;
    end
  end

  assign reconfig_req = r_req;
  assign sata_gen     = r_gen;
  assign link_up      = r_up;
  assign link_fail    = r_fail;
  assign state_out    = r_state;

endmodule
